// File: rtl/cmp_rs_if.sv
// rtl/cmp_rs_if.sv - dispatch, CDB and issue bus bundle for the comparator reservation station
interface cmp_rs_if #(
    parameter int TAG_WIDTH = 3
) ();
    logic                 dispatch_valid;
    logic                 dispatch_ready;
    logic [2:0]           dispatch_funct3;
    logic [TAG_WIDTH-1:0] dispatch_rob_tag;
    logic                 dispatch_src1_valid;
    logic                 dispatch_src2_valid;
    logic [31:0]          dispatch_src1_data;
    logic [31:0]          dispatch_src2_data;
    logic [TAG_WIDTH-1:0] dispatch_src1_tag;
    logic [TAG_WIDTH-1:0] dispatch_src2_tag;

    logic                 cdb_valid;
    logic [TAG_WIDTH-1:0] cdb_tag;
    logic [31:0]          cdb_data;

    logic                 issue_valid;
    logic                 issue_ready;
    logic [2:0]           issue_funct3;
    logic [31:0]          issue_first;
    logic [31:0]          issue_second;
    logic [TAG_WIDTH-1:0] issue_rob_tag;

    modport slave (
        input  dispatch_valid, dispatch_funct3, dispatch_rob_tag,
               dispatch_src1_valid, dispatch_src2_valid,
               dispatch_src1_data, dispatch_src2_data,
               dispatch_src1_tag, dispatch_src2_tag,
               cdb_valid, cdb_tag, cdb_data, issue_ready,
        output dispatch_ready, issue_valid, issue_funct3,
               issue_first, issue_second, issue_rob_tag
    );

    modport master (
        output dispatch_valid, dispatch_funct3, dispatch_rob_tag,
               dispatch_src1_valid, dispatch_src2_valid,
               dispatch_src1_data, dispatch_src2_data,
               dispatch_src1_tag, dispatch_src2_tag,
               cdb_valid, cdb_tag, cdb_data, issue_ready,
        input  dispatch_ready, issue_valid, issue_funct3,
               issue_first, issue_second, issue_rob_tag
    );
endinterface

// File: rtl/cmp_rs.sv
// rtl/cmp_rs.sv - compacting reservation station for the slt/sltu comparator unit
module cmp_rs #(
    parameter int RS_DEPTH  = 4,
    parameter int TAG_WIDTH = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    cmp_rs_if.slave     bus
);
    localparam int CW = $clog2(RS_DEPTH + 1);
    localparam int IW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    typedef struct packed {
        logic                 busy;
        logic [2:0]           funct3;
        logic [TAG_WIDTH-1:0] rob_tag;
        logic                 src1_valid;
        logic [31:0]          src1_data;
        logic [TAG_WIDTH-1:0] src1_tag;
        logic                 src2_valid;
        logic [31:0]          src2_data;
        logic [TAG_WIDTH-1:0] src2_tag;
    } entry_t;

    entry_t [RS_DEPTH-1:0] ent_q, ent_d;
    logic   [CW-1:0]       count_q, count_d;

    logic                  sel_found;
    logic   [IW-1:0]       sel_idx;
    entry_t                sel_ent;
    logic                  issue_fire;
    logic                  dispatch_fire;
    logic   [CW-1:0]       count_after;
    entry_t                new_ent;

    // Oldest ready entry: scan from the top so the lowest index wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (ent_q[i].busy && ent_q[i].src1_valid && ent_q[i].src2_valid) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    assign sel_ent = ent_q[sel_idx];

    // Issue side is a pure function of registered state; zeroed when idle.
    assign bus.issue_valid    = sel_found;
    assign bus.issue_funct3   = sel_found ? sel_ent.funct3    : 3'b000;
    assign bus.issue_first    = sel_found ? sel_ent.src1_data : 32'h0;
    assign bus.issue_second   = sel_found ? sel_ent.src2_data : 32'h0;
    assign bus.issue_rob_tag  = sel_found ? sel_ent.rob_tag   : '0;

    // A slot freed by a same-cycle issue is not offered to dispatch.
    assign bus.dispatch_ready = (count_q < CW'(RS_DEPTH));

    assign issue_fire    = sel_found && bus.issue_ready && !flush;
    assign dispatch_fire = bus.dispatch_valid && bus.dispatch_ready;

    // Next state: compact out the issued entry, append the dispatch, then snoop the CDB.
    always_comb begin
        ent_d       = ent_q;
        count_after = count_q - CW'(issue_fire);
        count_d     = count_after + CW'(dispatch_fire);

        new_ent            = '0;
        new_ent.busy       = 1'b1;
        new_ent.funct3     = bus.dispatch_funct3;
        new_ent.rob_tag    = bus.dispatch_rob_tag;
        new_ent.src1_valid = bus.dispatch_src1_valid;
        new_ent.src1_data  = bus.dispatch_src1_data;
        new_ent.src1_tag   = bus.dispatch_src1_tag;
        new_ent.src2_valid = bus.dispatch_src2_valid;
        new_ent.src2_data  = bus.dispatch_src2_data;
        new_ent.src2_tag   = bus.dispatch_src2_tag;

        if (issue_fire) begin
            for (int i = 0; i < RS_DEPTH - 1; i++) begin
                if (IW'(i) >= sel_idx) begin
                    ent_d[i] = ent_q[i + 1];
                end
            end
            ent_d[RS_DEPTH-1] = '0;
        end

        if (dispatch_fire) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (CW'(i) == count_after) begin
                    ent_d[i] = new_ent;
                end
            end
        end

        // Wakeup runs on the post-shift image, so the new entry gets the bypass for free.
        if (bus.cdb_valid) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (ent_d[i].busy && !ent_d[i].src1_valid && ent_d[i].src1_tag == bus.cdb_tag) begin
                    ent_d[i].src1_valid = 1'b1;
                    ent_d[i].src1_data  = bus.cdb_data;
                end
                if (ent_d[i].busy && !ent_d[i].src2_valid && ent_d[i].src2_tag == bus.cdb_tag) begin
                    ent_d[i].src2_valid = 1'b1;
                    ent_d[i].src2_data  = bus.cdb_data;
                end
            end
        end

        if (flush) begin
            ent_d   = '0;
            count_d = '0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q   <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_cmp_rs.sv
// tb/tb_cmp_rs.sv - scoreboard bench for cmp_rs with a queue-level reference model
module tb_cmp_rs;
    localparam int TW    = 3;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    cmp_rs_if #(.TAG_WIDTH(TW)) bus ();

    cmp_rs #(.RS_DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]    f3;
        logic [TW-1:0] tag;
        bit            v1;
        bit            v2;
        logic [31:0]   d1;
        logic [31:0]   d2;
        logic [TW-1:0] t1;
        logic [TW-1:0] t2;
    } ment_t;

    typedef struct {
        logic [2:0]    f3;
        logic [31:0]   a;
        logic [31:0]   b;
        logic [TW-1:0] tag;
    } exp_t;

    ment_t mq[$];
    exp_t  exp_q[$];
    int    errors = 0;
    int    checks = 0;
    bit    mon_en = 1'b0;
    bit    exp_iv;
    bit    exp_dr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic idle();
        rst                     = 1'b0;
        flush                   = 1'b0;
        bus.dispatch_valid      = 1'b0;
        bus.dispatch_funct3     = 3'b000;
        bus.dispatch_rob_tag    = '0;
        bus.dispatch_src1_valid = 1'b0;
        bus.dispatch_src2_valid = 1'b0;
        bus.dispatch_src1_data  = 32'h0;
        bus.dispatch_src2_data  = 32'h0;
        bus.dispatch_src1_tag   = '0;
        bus.dispatch_src2_tag   = '0;
        bus.cdb_valid           = 1'b0;
        bus.cdb_tag             = '0;
        bus.cdb_data            = 32'h0;
        bus.issue_ready         = 1'b0;
    endtask

    task automatic disp(input logic [2:0] f3, input logic [TW-1:0] tag,
                        input bit v1, input logic [31:0] d1, input logic [TW-1:0] t1,
                        input bit v2, input logic [31:0] d2, input logic [TW-1:0] t2);
        bus.dispatch_valid      = 1'b1;
        bus.dispatch_funct3     = f3;
        bus.dispatch_rob_tag    = tag;
        bus.dispatch_src1_valid = v1;
        bus.dispatch_src1_data  = d1;
        bus.dispatch_src1_tag   = t1;
        bus.dispatch_src2_valid = v2;
        bus.dispatch_src2_data  = d2;
        bus.dispatch_src2_tag   = t2;
    endtask

    task automatic cdb(input logic [TW-1:0] tag, input logic [31:0] data);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = tag;
        bus.cdb_data  = data;
    endtask

    // One clock: predict this cycle's outputs, then advance the model with the applied inputs.
    task automatic step();
        int    sel;
        bit    dfire;
        exp_t  e;
        ment_t m;
        sel = -1;
        for (int i = 0; i < mq.size(); i++) begin
            if (sel < 0 && mq[i].v1 && mq[i].v2) sel = i;
        end
        exp_iv = (sel >= 0);
        exp_dr = (mq.size() < DEPTH);
        if (sel >= 0 && bus.issue_ready) begin
            e.f3  = mq[sel].f3;
            e.a   = mq[sel].d1;
            e.b   = mq[sel].d2;
            e.tag = mq[sel].tag;
            exp_q.push_back(e);
        end
        @(negedge clk);
        dfire = bus.dispatch_valid && (mq.size() < DEPTH);
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (sel >= 0 && bus.issue_ready) mq.delete(sel);
            if (dfire) begin
                m.f3  = bus.dispatch_funct3;
                m.tag = bus.dispatch_rob_tag;
                m.v1  = bus.dispatch_src1_valid;
                m.d1  = bus.dispatch_src1_data;
                m.t1  = bus.dispatch_src1_tag;
                m.v2  = bus.dispatch_src2_valid;
                m.d2  = bus.dispatch_src2_data;
                m.t2  = bus.dispatch_src2_tag;
                mq.push_back(m);
            end
            if (bus.cdb_valid) begin
                foreach (mq[i]) begin
                    if (!mq[i].v1 && mq[i].t1 == bus.cdb_tag) begin
                        mq[i].v1 = 1'b1;
                        mq[i].d1 = bus.cdb_data;
                    end
                    if (!mq[i].v2 && mq[i].t2 == bus.cdb_tag) begin
                        mq[i].v2 = 1'b1;
                        mq[i].d2 = bus.cdb_data;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare handshake levels every cycle and pop the scoreboard on each issue.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("issue_valid", 32'(bus.issue_valid), 32'(exp_iv));
            chk("dispatch_ready", 32'(bus.dispatch_ready), 32'(exp_dr));
            if (bus.issue_valid && bus.issue_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_issue", 32'(bus.issue_rob_tag), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("issue_funct3", 32'(bus.issue_funct3), 32'(e.f3));
                    chk("issue_first", bus.issue_first, e.a);
                    chk("issue_second", bus.issue_second, e.b);
                    chk("issue_rob_tag", 32'(bus.issue_rob_tag), 32'(e.tag));
                end
            end
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_issue_valid", 32'(bus.issue_valid), 32'h0);
        chk("rst_dispatch_ready", 32'(bus.dispatch_ready), 32'h1);
        chk("rst_funct3", 32'(bus.issue_funct3), 32'h0);
        chk("rst_first", bus.issue_first, 32'h0);
        chk("rst_second", bus.issue_second, 32'h0);
        chk("rst_rob_tag", 32'(bus.issue_rob_tag), 32'h0);
        mon_en = 1'b1;

        // Both operands ready at dispatch: one-cycle latency.
        disp(3'b010, 3'd2, 1'b1, 32'hFFFF_FFFF, 3'd0, 1'b1, 32'h1, 3'd0);
        step(); idle();
        chk("t1_valid", 32'(bus.issue_valid), 32'h1);
        chk("t1_funct3", 32'(bus.issue_funct3), 32'h2);
        chk("t1_first", bus.issue_first, 32'hFFFF_FFFF);
        chk("t1_second", bus.issue_second, 32'h1);
        chk("t1_tag", 32'(bus.issue_rob_tag), 32'h2);
        bus.issue_ready = 1'b1;
        step(); idle();
        chk("t1_drained", 32'(bus.issue_valid), 32'h0);

        // Wait on src1 tag 5, broadcast two cycles later.
        disp(3'b011, 3'd1, 1'b0, 32'h0, 3'd5, 1'b1, 32'h20, 3'd0);
        step(); idle();
        step();
        chk("t2_waiting", 32'(bus.issue_valid), 32'h0);
        cdb(3'd5, 32'h10);
        step(); idle();
        chk("t2_woken", 32'(bus.issue_valid), 32'h1);
        chk("t2_first", bus.issue_first, 32'h10);
        bus.issue_ready = 1'b1;
        step(); idle();

        // Dispatch bypass from a same-cycle broadcast.
        disp(3'b010, 3'd6, 1'b1, 32'h5, 3'd0, 1'b0, 32'h0, 3'd3);
        cdb(3'd3, 32'h7);
        step(); idle();
        chk("t3_valid", 32'(bus.issue_valid), 32'h1);
        chk("t3_second", bus.issue_second, 32'h7);
        bus.issue_ready = 1'b1;
        step(); idle();

        // Fill to capacity, fifth dispatch refused, then age-ordered drain.
        for (int k = 0; k < DEPTH; k++) begin
            disp(3'b010, TW'(k), 1'b1, 32'(k), 3'd0, 1'b1, 32'(100 + k), 3'd0);
            step();
        end
        idle();
        chk("t4_full", 32'(bus.dispatch_ready), 32'h0);
        disp(3'b010, 3'd4, 1'b1, 32'h44, 3'd0, 1'b1, 32'h44, 3'd0);
        step(); idle();
        bus.issue_ready = 1'b1;
        step(); idle();
        chk("t4_slot_freed", 32'(bus.dispatch_ready), 32'h1);
        chk("t4_next_oldest", 32'(bus.issue_rob_tag), 32'h1);
        for (int k = 0; k < 3; k++) begin
            bus.issue_ready = 1'b1;
            step();
        end
        idle();
        chk("t4_empty", 32'(bus.issue_valid), 32'h0);

        // Younger ready entry bypasses an older waiting one.
        disp(3'b010, 3'd5, 1'b0, 32'h0, 3'd4, 1'b1, 32'h9, 3'd0);
        step();
        disp(3'b011, 3'd6, 1'b1, 32'h1, 3'd0, 1'b1, 32'h2, 3'd0);
        step(); idle();
        chk("t5_younger_first", 32'(bus.issue_rob_tag), 32'h6);
        bus.issue_ready = 1'b1;
        step(); idle();
        chk("t5_older_waits", 32'(bus.issue_valid), 32'h0);
        cdb(3'd4, 32'h77);
        step(); idle();
        chk("t5_older_tag", 32'(bus.issue_rob_tag), 32'h5);
        chk("t5_older_first", bus.issue_first, 32'h77);
        bus.issue_ready = 1'b1;
        step(); idle();

        // Flush with a concurrent dispatch.
        for (int k = 0; k < 3; k++) begin
            disp(3'b011, TW'(k), 1'b1, 32'(k), 3'd0, 1'b1, 32'(k), 3'd0);
            step();
        end
        idle();
        flush = 1'b1;
        disp(3'b010, 3'd7, 1'b1, 32'h1, 3'd0, 1'b1, 32'h1, 3'd0);
        step(); idle();
        chk("t6_flush_valid", 32'(bus.issue_valid), 32'h0);
        chk("t6_flush_ready", 32'(bus.dispatch_ready), 32'h1);
        step();
        chk("t6_dispatch_dropped", 32'(bus.issue_valid), 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            idle();
            if ($urandom_range(99) < 60) begin
                disp(($urandom_range(3) == 0) ? 3'($urandom) : 3'($urandom_range(3, 2)),
                     TW'($urandom),
                     1'($urandom_range(1)), $urandom, TW'($urandom),
                     1'($urandom_range(1)), $urandom, TW'($urandom));
            end
            if ($urandom_range(99) < 50) cdb(TW'($urandom), $urandom);
            bus.issue_ready = ($urandom_range(99) < 65);
            flush = ($urandom_range(99) < 3);
            rst   = ($urandom_range(199) < 1);
            step();
        end

        idle();
        flush = 1'b1;
        step(); idle();
        step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
